// File: rtl/cpu_step_pkg.sv
// Shared encodings for the CPU step controller: run modes and auto-repeat FSM states.
package cpu_step_pkg;

    localparam logic [1:0] MODE_RUN  = 2'd0;
    localparam logic [1:0] MODE_SLOW = 2'd1;
    localparam logic [1:0] MODE_STEP = 2'd2;

    localparam logic [1:0] RPT_IDLE   = 2'd0;
    localparam logic [1:0] RPT_HOLD   = 2'd1;
    localparam logic [1:0] RPT_REPEAT = 2'd2;

    // MODE button cycles RUN -> SLOW -> STEP -> RUN; the unused code recovers to RUN.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        case (mode)
            MODE_RUN:  next_mode = MODE_SLOW;
            MODE_SLOW: next_mode = MODE_STEP;
            default:   next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/step_interval_timer.sv
// Interval counter shared by SLOW and STEP modes: counts 0..term_i, wraps, flags terminal count.
module step_interval_timer #(
    parameter int CW = 25
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          count_i,
    input  logic [CW-1:0] term_i,
    output logic          tc_o
);

    logic [CW-1:0] count_q, count_d;

    assign tc_o = count_i && (count_q == term_i);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = tc_o ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_step_control.sv
// Clock-enable generator for the core: RUN / SLOW / STEP modes with press-and-hold auto-repeat.
module cpu_step_control
    import cpu_step_pkg::*;
#(
    parameter int SLOW_DIV      = 25_000_000,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CW            = 25
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iStepPulse,
    input  logic       iStepState,
    input  logic       iModePulse,
    input  logic       iHalt,
    output logic       oCpuEnable,
    output logic [1:0] oMode,
    output logic       oHalted
);

    localparam logic [CW-1:0] SLOW_TERM   = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] HOLD_TERM   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TERM = CW'(REPEAT_CYCLES - 1);

    logic [1:0]    mode_q, mode_d;
    logic [1:0]    rpt_q, rpt_d;
    logic          halted_q, halted_d;
    logic          en_q, en_d;
    logic          tmr_clear, tmr_count, tmr_tc;
    logic [CW-1:0] tmr_term;

    step_interval_timer #(.CW(CW)) u_timer (
        .clk_i   (iClock),
        .rst_i   (iReset),
        .clear_i (tmr_clear),
        .count_i (tmr_count),
        .term_i  (tmr_term),
        .tc_o    (tmr_tc)
    );

    // Priority: mode pulse, then halt, then step/timer events.
    always_comb begin
        mode_d    = mode_q;
        rpt_d     = rpt_q;
        halted_d  = halted_q;
        en_d      = 1'b0;
        tmr_clear = 1'b0;
        tmr_count = 1'b0;
        tmr_term  = SLOW_TERM;
        if (iModePulse) begin
            mode_d    = next_mode(mode_q);
            rpt_d     = RPT_IDLE;
            halted_d  = 1'b0;
            tmr_clear = 1'b1;
        end else begin
            if (iHalt) begin
                halted_d = 1'b1;
            end
            case (mode_q)
                MODE_RUN: begin
                    tmr_clear = 1'b1;
                    en_d      = !halted_q && !iHalt;
                end
                MODE_SLOW: begin
                    tmr_count = 1'b1;
                    en_d      = tmr_tc && !halted_q && !iHalt;
                end
                MODE_STEP: begin
                    // Halt is deliberately ignored here so the user can step past a break.
                    case (rpt_q)
                        RPT_HOLD, RPT_REPEAT: begin
                            tmr_term = (rpt_q == RPT_HOLD) ? HOLD_TERM : REPEAT_TERM;
                            if (!iStepState) begin
                                rpt_d     = RPT_IDLE;
                                tmr_clear = 1'b1;
                            end else begin
                                tmr_count = 1'b1;
                                if (tmr_tc) begin
                                    en_d  = 1'b1;
                                    rpt_d = RPT_REPEAT;
                                end
                            end
                        end
                        default: begin
                            rpt_d     = RPT_IDLE;
                            tmr_clear = 1'b1;
                            if (iStepPulse) begin
                                en_d  = 1'b1;
                                rpt_d = RPT_HOLD;
                            end
                        end
                    endcase
                end
                default: begin
                    mode_d    = MODE_STEP;
                    rpt_d     = RPT_IDLE;
                    tmr_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            mode_q   <= MODE_STEP;
            rpt_q    <= RPT_IDLE;
            halted_q <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            rpt_q    <= rpt_d;
            halted_q <= halted_d;
            en_q     <= en_d;
        end
    end

    assign oCpuEnable = en_q;
    assign oMode      = mode_q;
    assign oHalted    = halted_q;

endmodule

// File: tb/tb_cpu_step_control.sv
// Directed vector bench for cpu_step_control with small timing parameters.
module tb_cpu_step_control;

    typedef struct {
        logic       sp;
        logic       ss;
        logic       mp;
        logic       hl;
        logic       exp_en;
        logic [1:0] exp_mode;
        logic       exp_halted;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_pulse, step_state, mode_pulse, halt;
    logic       cpu_en;
    logic [1:0] mode;
    logic       halted;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_step_control #(
        .SLOW_DIV      (4),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (3),
        .CW            (4)
    ) dut (
        .iClock     (clk),
        .iReset     (rst),
        .iStepPulse (step_pulse),
        .iStepState (step_state),
        .iModePulse (mode_pulse),
        .iHalt      (halt),
        .oCpuEnable (cpu_en),
        .oMode      (mode),
        .oHalted    (halted)
    );

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic sp, input logic ss, input logic mp, input logic hl,
                       input logic en, input logic [1:0] md, input logic hd);
        vec_t v;
        v.sp = sp; v.ss = ss; v.mp = mp; v.hl = hl;
        v.exp_en = en; v.exp_mode = md; v.exp_halted = hd;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step_pulse = 1'b0; step_state = 1'b0; mode_pulse = 1'b0; halt = 1'b0;

        // Single press, button released at once: one enable, then silence.
        for (int t = 0; t < 15; t++)
            add(t == 10, 1'b0, 1'b0, 1'b0, t == 11, 2'd2, 1'b0);
        // Press held for 30 cycles: hold delay then auto-repeat.
        for (int t = 0; t < 35; t++)
            add(t == 0, t < 30, 1'b0, 1'b0,
                (t == 1) || (t == 9) || (t >= 12 && t <= 30 && (t - 12) % 3 == 0), 2'd2, 1'b0);
        // Mode pulse with step pulse: step is lost, RUN follows.
        add(1, 1, 1, 0, 0, 2'd2, 0);
        add(0, 0, 0, 0, 0, 2'd0, 0);
        add(0, 0, 0, 0, 1, 2'd0, 0);
        add(0, 0, 0, 0, 1, 2'd0, 0);
        // Enter SLOW; halt at s+7 suppresses later enables.
        add(0, 0, 1, 0, 1, 2'd0, 0);
        for (int t = 1; t <= 14; t++)
            add(1'b0, 1'b0, 1'b0, t == 7, t == 5, 2'd1, t >= 8);
        add(0, 0, 1, 0, 0, 2'd1, 1);
        add(0, 0, 0, 0, 0, 2'd2, 0);
        add(0, 0, 1, 0, 0, 2'd2, 0);
        add(0, 0, 0, 0, 0, 2'd0, 0);
        add(0, 0, 0, 0, 1, 2'd0, 0);
        add(0, 0, 0, 1, 1, 2'd0, 0);
        add(0, 0, 0, 0, 0, 2'd0, 1);
        add(0, 0, 1, 0, 0, 2'd0, 1);
        add(0, 0, 1, 0, 0, 2'd1, 0);
        // STEP: halt does not block a step.
        add(1, 0, 0, 1, 0, 2'd2, 0);
        add(0, 0, 0, 0, 1, 2'd2, 1);
        add(0, 0, 0, 0, 0, 2'd2, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset en", {1'b0, cpu_en}, 2'd0);
        check("reset mode", mode, 2'd2);
        check("reset halted", {1'b0, halted}, 2'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step_pulse = vecs[i].sp;
            step_state = vecs[i].ss;
            mode_pulse = vecs[i].mp;
            halt       = vecs[i].hl;
            check($sformatf("vec%0d en", i), {1'b0, cpu_en}, {1'b0, vecs[i].exp_en});
            check($sformatf("vec%0d mode", i), mode, vecs[i].exp_mode);
            check($sformatf("vec%0d halted", i), {1'b0, halted}, {1'b0, vecs[i].exp_halted});
            tick();
        end
        step_pulse = 1'b0; step_state = 1'b0; mode_pulse = 1'b0; halt = 1'b0;

        // Async reset during a REPEAT enable, with the halt flag still set.
        step_pulse = 1'b1;
        step_state = 1'b1;
        tick();
        step_pulse = 1'b0;
        repeat (11) tick();
        check("pre-reset en", {1'b0, cpu_en}, 2'd1);
        check("pre-reset halted", {1'b0, halted}, 2'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset en", {1'b0, cpu_en}, 2'd0);
        check("async reset mode", mode, 2'd2);
        check("async reset halted", {1'b0, halted}, 2'd0);
        tick();
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            check($sformatf("post-reset idle %0d", t), {1'b0, cpu_en}, 2'd0);
            tick();
        end
        step_state = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
